// File: rtl/syn_fifo_pkg.sv
// Shared types and helpers for the syn_fifo drain-side reader.
package syn_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 3;

  // Advance a buffer pointer, wrapping after the last of the three slots.
  function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
    return (ptr == 2'(BUF_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/syn_fifo_skid3.sv
// Three-entry circular output buffer: absorbs the FIFO read latency so a
// stalled consumer never causes a dropped or duplicated word.
module syn_fifo_skid3
  import syn_fifo_pkg::*;
#(
  parameter int width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic [1:0]       count
);

  logic [width-1:0] mem [0:BUF_DEPTH-1];
  logic [1:0]       head;
  logic [1:0]       tail;

  assign head_data = mem[head];

  // Pointer and occupancy control; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 2'd0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/syn_fifo_reader.sv
// Drain-side companion to syn_fifo: pops FIFO words and re-presents them on
// a valid/ready stream with burst tagging and a delivered-word counter.
module syn_fifo_reader
  import syn_fifo_pkg::*;
#(
  parameter int fifo_depth = 8,
  parameter int fifo_width = $clog2(fifo_depth),
  parameter int burst_len  = 4,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  emp_fg,
  output logic                  rd_en,
  input  logic [fifo_width-1:0] rdata,
  output logic [fifo_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [cnt_width-1:0]  words_out
);

  localparam logic [cnt_width-1:0] WORD_INC  = 1;
  localparam logic [7:0]           LAST_BEAT = 8'(burst_len - 1);

  state_t     state;
  logic       rd_q;
  logic [1:0] count;
  logic [7:0] beat_cnt;
  logic       hs;

  // Pop only while running, and only if the buffer can hold the word plus
  // any pop already in flight; no path from m_ready by construction.
  assign rd_en   = ~rst & (state == RUN) & ~emp_fg
                 & ((3'(count) + 3'(rd_q)) <= 3'd2);
  assign m_valid = (count != 2'd0);
  assign hs      = m_valid & m_ready;
  assign m_last  = m_valid & (beat_cnt == LAST_BEAT);
  assign busy    = (state != IDLE);

  syn_fifo_skid3 #(
    .width(fifo_width)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_q),
    .push_data(rdata),
    .pop      (hs),
    .head_data(m_data),
    .count    (count)
  );

  // Run/drain control: DRAIN finishes the in-flight pop and empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable)                             state <= RUN;
          else if ((count == 2'd0) && !rd_q)      state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered copy of an accepted pop: marks rdata valid next cycle.
  always_ff @(posedge clk) begin
    if (rst) rd_q <= 1'b0;
    else     rd_q <= rd_en;
  end

  // Burst position and delivered-word count advance on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= 8'd0;
      words_out <= '0;
    end else if (hs) begin
      beat_cnt  <= m_last ? 8'd0 : beat_cnt + 8'd1;
      words_out <= words_out + WORD_INC;
    end
  end

endmodule

// File: tb/tb_syn_fifo_reader.sv
// Scoreboard bench for syn_fifo_reader: a queue-based FIFO model feeds the
// DUT, every accepted pop pushes its expected word, and a negedge monitor
// pops and compares on each stream handshake.
module tb_syn_fifo_reader;

  localparam int DEPTH = 8;
  localparam int W     = 3;
  localparam int BL    = 4;
  localparam int CW    = 16;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          emp_fg = 1'b1;
  logic          rd_en;
  logic [W-1:0]  rdata = '0;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] words_out;

  syn_fifo_reader #(
    .fifo_depth(DEPTH),
    .fifo_width(W),
    .burst_len (BL),
    .cnt_width (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .emp_fg   (emp_fg),
    .rd_en    (rd_en),
    .rdata    (rdata),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .words_out(words_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           tests = 0;
  int           fails = 0;
  exp_t         exp_q[$];
  logic [W-1:0] fifo_q[$];
  bit           pend_valid = 0;
  logic [W-1:0] pend_word = '0;
  bit           rdq_model = 0;
  int           pops_total = 0;
  int           pop_idx = 0;
  int           model_words = 0;
  int           hs_n = 0;
  int           first_hs = 0;
  int           last_hs = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_data = '0;
  bit           rand_ready = 0;

  task automatic check(input string name, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor and FIFO model: decisions made at negedge on stable DUT outputs.
  always @(negedge clk) begin
    exp_t         e;
    logic [W-1:0] w;
    if (rst) begin
      check("rd_en_in_reset", rd_en, 0);
      exp_q.delete();
      model_words = 0;
      pop_idx     = 0;
      pend_valid  = 0;
      prev_stall  = 0;
    end else begin
      if (rd_en) check("rd_en_while_empty", emp_fg, 0);
      check("words_out", words_out, model_words);
      if (!m_valid) check("m_last_without_valid", m_last, 0);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0d, expected no word", m_data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
        end
        model_words = (model_words + 1) % (1 << CW);
        if (hs_n == 0) first_hs = cyc;
        last_hs = cyc;
        hs_n++;
      end
      if (rd_en && !emp_fg && fifo_q.size() != 0) begin
        w      = fifo_q.pop_front();
        e.data = w;
        e.last = ((pop_idx % BL) == BL - 1);
        exp_q.push_back(e);
        pop_idx++;
        pops_total++;
        pend_valid = 1;
        pend_word  = w;
        check("outstanding_le_3", exp_q.size() <= 3, 1);
      end
    end
  end

  // One clock: present last cycle's popped word on rdata, refresh emp_fg.
  task automatic step();
    @(posedge clk);
    #1;
    rdq_model  = pend_valid;
    rdata      = pend_valid ? pend_word : W'($urandom);
    pend_valid = 0;
    emp_fg     = (fifo_q.size() == 0);
    if (rand_ready) m_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(name, n < budget, 1);
  endtask

  task automatic preload();
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(W'(i));
  endtask

  initial begin
    int rel;
    int p0;
    int p1;
    int pushed;
    int n;
    int remaining;

    // Reset with a non-empty FIFO and enable high
    rst = 1; enable = 1; m_ready = 1;
    preload();
    step(); step(); step();
    @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_words_out", words_out, 0);
    check("reset_busy", busy, 0);
    step();
    rst = 0; rel = cyc; hs_n = 0;
    @(negedge clk);
    check("idle_rd_en", rd_en, 0);
    check("idle_busy", busy, 0);
    step();
    @(negedge clk);
    check("first_rd_en", rd_en, 1);
    check("run_busy", busy, 1);

    // Streaming 0..7 with m_ready held high
    wait_drained("stream_drained", 40);
    check("first_word_latency", first_hs - rel, 3);
    check("stream_back_to_back", last_hs - first_hs, 7);
    check("stream_words", hs_n, 8);
    step();
    @(negedge clk);
    check("stream_words_out", words_out, 8);
    check("stream_rd_en_low", rd_en, 0);

    // Back-pressure: consumer stalled for 10 cycles
    m_ready = 0; rst = 1;
    step(); preload(); step();
    rst = 0; hs_n = 0; p0 = pops_total;
    for (int i = 0; i < 10; i++) step();
    check("bp_pops", pops_total - p0, 3);
    @(negedge clk);
    check("bp_valid", m_valid, 1);
    check("bp_head_data", m_data, 0);
    m_ready = 1;
    wait_drained("bp_drained", 60);
    check("bp_words", hs_n, 8);

    // Random ready with an intermittently filled FIFO
    rst = 1;
    step(); fifo_q.delete(); step();
    rst = 0; hs_n = 0; rand_ready = 1; pushed = 0; n = 0;
    while ((pushed < 64 || fifo_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      step();
      n++;
      if (pushed < 64 && fifo_q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        fifo_q.push_back(W'($urandom));
        pushed++;
      end
    end
    rand_ready = 0; m_ready = 1;
    check("rand_finished", n < 3000, 1);
    check("rand_words", hs_n, 64);

    // Drain: enable dropped right after the first accepted pop
    rst = 1;
    step(); preload(); step();
    rst = 0; hs_n = 0; p0 = pops_total; n = 0;
    while (pops_total == p0 && n < 20) begin
      step();
      n++;
    end
    check("drain_first_pop", pops_total - p0 >= 1, 1);
    enable = 0;
    step();
    p1 = pops_total;
    for (int i = 0; i < 10; i++) step();
    check("drain_no_new_pops", pops_total, p1);
    check("drain_delivered", hs_n, pops_total - p0);
    check("drain_buffer_empty", exp_q.size(), 0);
    @(negedge clk);
    check("drain_busy", busy, 0);
    check("drain_rd_en", rd_en, 0);

    // Mid-operation reset with two buffered words and one pop in flight
    rst = 1; enable = 1;
    step(); preload(); step();
    rst = 0; hs_n = 0; m_ready = 1; n = 0;
    while (hs_n < 2 && n < 20) begin
      step();
      n++;
    end
    m_ready = 0; n = 0;
    while (!(exp_q.size() == 3 && rdq_model) && n < 20) begin
      step();
      n++;
    end
    check("midrst_reached", n < 20, 1);
    rst = 1;
    remaining = fifo_q.size();
    step();
    rst = 0;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_words_out", words_out, 0);
    check("midrst_busy", busy, 0);
    m_ready = 1; hs_n = 0;
    wait_drained("midrst_drained", 60);
    check("midrst_words", hs_n, remaining);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
